// File: rtl/branch_resolve_unit_if.sv
// Execute-to-fetch bundle of the branch resolve unit.
// The unit is the slave; fetch and execute together form the master side.
interface branch_resolve_unit_if;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic        resolve_valid_e;
  logic        is_cond_e;
  logic [31:0] pc_e;
  logic        taken_e;
  logic [31:0] target_e;
  logic        pred_taken_e;
  logic [31:0] pred_target_e;
  logic        stall_e;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_fd;
  logic        flush_de;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport slave (
    input  pc_f, resolve_valid_e, is_cond_e, pc_e, taken_e, target_e,
           pred_taken_e, pred_target_e, stall_e,
    output pred_taken_f, redirect_valid, redirect_pc, flush_fd, flush_de,
           branch_count, mispredict_count
  );

  modport master (
    output pc_f, resolve_valid_e, is_cond_e, pc_e, taken_e, target_e,
           pred_taken_e, pred_target_e, stall_e,
    input  pred_taken_f, redirect_valid, redirect_pc, flush_fd, flush_de,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves branches in execute, issues a one-cycle registered redirect/flush on
// mispredict, and trains the PC-indexed 2-bit counter table that fetch reads.
module branch_resolve_unit #(
  parameter int         INDEX_BITS  = 6,
  parameter logic [1:0] RESET_STATE = 2'b01
) (
  input logic                 clk,
  input logic                 rst,
  branch_resolve_unit_if.slave bus
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            table_q [ENTRIES];
  logic [INDEX_BITS-1:0] idxF;
  logic [INDEX_BITS-1:0] idxE;
  logic [1:0]            ctrE;
  logic [1:0]            ctr_d;

  logic        accept;
  logic        mispredict;
  logic        train;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  assign idxF = bus.pc_f[INDEX_BITS+1:2];
  assign idxE = bus.pc_e[INDEX_BITS+1:2];
  assign ctrE = table_q[idxE];

  // The cycle right after a redirect carries a wrong-path instruction, so it is never accepted.
  assign accept     = bus.resolve_valid_e & ~bus.stall_e & ~redirect_valid_q;
  assign mispredict = accept & ((bus.taken_e != bus.pred_taken_e) |
                                (bus.taken_e & (bus.target_e != bus.pred_target_e)));
  assign train      = accept & bus.is_cond_e;

  always_comb begin
    ctr_d = ctrE;
    if (bus.taken_e) begin
      if (ctrE != 2'b11) ctr_d = ctrE + 2'd1;
    end else begin
      if (ctrE != 2'b00) ctr_d = ctrE - 2'd1;
    end
  end

  always_comb begin
    redirect_valid_d   = mispredict;
    redirect_pc_d      = redirect_pc_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (mispredict) begin
      redirect_pc_d      = bus.taken_e ? bus.target_e : bus.pc_e + 32'd4;
      mispredict_count_d = mispredict_count_q + 32'd1;
    end
    if (train) branch_count_d = branch_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= RESET_STATE;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= 32'd0;
      branch_count_q     <= 32'd0;
      mispredict_count_q <= 32'd0;
    end else begin
      if (train) table_q[idxE] <= ctr_d;
      redirect_valid_q   <= redirect_valid_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  // Fetch sees the pre-update counter when it looks up the entry being trained.
  assign bus.pred_taken_f     = table_q[idxF][1];
  assign bus.redirect_valid   = redirect_valid_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.flush_fd         = redirect_valid_q;
  assign bus.flush_de         = redirect_valid_q;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

endmodule
